reg_file: RTL and testbench

Parametrised general-purpose register file for the datapath: DEPTH entries of WIDTH bits with two combinational read ports, one write port with same-cycle write-to-read forwarding, an optional hard-wired-zero entry 0, and a sequential soft-clear engine. It replaces the individually instantiated 32-bit enable registers in the register-file section of the datapath. The control unit drives it; the A/B operand buses read from it.

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_file_cell.sv | 16 +
 rtl/reg_file.sv | 61 ++++++
 tb/tb_reg_file.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared state encoding, default geometry and address-width helper for reg_file.
package reg_file_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_e;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/reg_file_cell.sv
// reg_cell: one register-file entry with async clear, synchronous zero and write enable.
module reg_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_zero,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) o_q <= '0;
    else if (i_zero) o_q <= '0;
    else if (i_we) o_q <= i_d;
endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file, two combinational read ports with write bypass,
// optional hard-wired zero entry and a one-entry-per-cycle soft-clear walk.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int ZERO_R0 = 1,
  parameter  int BYPASS  = 1,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             scrub_req,
  output logic             busy
);
  state_e          r_state;
  logic [AW-1:0]   r_idx;
  logic            w_we;
  logic [WIDTH-1:0] w_q [DEPTH];
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else if (r_state == IDLE) begin
      r_state <= scrub_req ? CLEAR : IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= (r_idx == AW'(DEPTH - 1)) ? IDLE : CLEAR;
      r_idx   <= r_idx + 1'b1;
    end
  assign busy = (r_state == CLEAR);
  assign w_we = wr_en && (r_state == IDLE) && (int'(wr_addr) < DEPTH) &&
                !((ZERO_R0 != 0) && (wr_addr == '0));
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if ((ZERO_R0 != 0) && (i == 0)) begin : g_zero
      assign w_q[i] = '0;
    end else begin : g_cell
      reg_cell #(.WIDTH(WIDTH)) u_cell (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_zero (busy && (r_idx == AW'(i))),
        .i_we   (w_we && (wr_addr == AW'(i))),
        .i_d    (wr_data),
        .o_q    (w_q[i])
      );
    end
  end
  // Range and zero-entry checks come first so out-of-range addresses never index w_q.
  assign rd_data_a = ((int'(rd_addr_a) >= DEPTH) || ((ZERO_R0 != 0) && (rd_addr_a == '0))) ? '0 :
                     ((BYPASS != 0) && w_we && (rd_addr_a == wr_addr)) ? wr_data : w_q[rd_addr_a];
  assign rd_data_b = ((int'(rd_addr_b) >= DEPTH) || ((ZERO_R0 != 0) && (rd_addr_b == '0))) ? '0 :
                     ((BYPASS != 0) && w_we && (rd_addr_b == wr_addr)) ? wr_data : w_q[rd_addr_b];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: three reg_file configurations driven in lockstep and checked against a behavioural model.
module tb_reg_file;
  logic        clk = 0;
  logic        clr_n, wr_en, scrub_req;
  logic [3:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wr_data;
  logic [31:0] ra [3];
  logic [31:0] rb [3];
  logic        bz [3];
  int total = 0, bad = 0;
  int          dep [3] = '{16, 16, 12};
  bit          zr  [3] = '{1, 0, 1};
  bit          bp  [3] = '{1, 0, 1};
  logic [31:0] mem [3][16];
  int          pos [3];
  always #5 clk = ~clk;
  reg_file #(.DEPTH(16), .ZERO_R0(1), .BYPASS(1)) u0 (.clk(clk), .clr_n(clr_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(ra[0]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rb[0]), .scrub_req(scrub_req), .busy(bz[0]));
  reg_file #(.DEPTH(16), .ZERO_R0(0), .BYPASS(0)) u1 (.clk(clk), .clr_n(clr_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(ra[1]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rb[1]), .scrub_req(scrub_req), .busy(bz[1]));
  reg_file #(.DEPTH(12), .ZERO_R0(1), .BYPASS(1)) u2 (.clk(clk), .clr_n(clr_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(ra[2]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rb[2]), .scrub_req(scrub_req), .busy(bz[2]));

  function automatic bit we_now(int k);
    return wr_en && pos[k] < 0 && int'(wr_addr) < dep[k] && !(zr[k] && wr_addr == 0);
  endfunction
  function automatic logic [31:0] exp_rd(int k, logic [3:0] a);
    if (int'(a) >= dep[k] || (zr[k] && a == 0)) return 0;
    if (bp[k] && we_now(k) && a == wr_addr) return wr_data;
    return mem[k][a];
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pos[k] = -1;
      for (int a = 0; a < 16; a++) mem[k][a] = 0;
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 3; k++)
      if (pos[k] >= 0) begin
        mem[k][pos[k]] = 0;
        pos[k]++;
        if (pos[k] == dep[k]) pos[k] = -1;
      end else begin
        if (we_now(k)) mem[k][wr_addr] = wr_data;
        if (scrub_req) pos[k] = 0;
      end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic fill(input bit rnd);
    for (int a = 0; a < 16; a++) begin
      wr_en = 1; wr_addr = 4'(a); wr_data = rnd ? $urandom | 1 : a + 1;
      cyc();
    end
    wr_en = 0;
  endtask

  task automatic test_reset();
    clr_n = 0; wr_en = 0; scrub_req = 0; wr_addr = 0; wr_data = 0;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a); rd_addr_b = 4'(15 - a); #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (ra[k] !== 0 || rb[k] !== 0 || bz[k] !== 0) begin
          bad++; $display("FAIL reset u%0d addr %0d got a=%h b=%h busy=%b exp 0", k, a, ra[k], rb[k], bz[k]);
        end
      end
    end
    @(negedge clk); clr_n = 1; @(negedge clk);
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    cyc();
    wr_en = 0; rd_addr_a = 5; rd_addr_b = 5; #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ra[k] !== 32'hDEADBEEF || rb[k] !== 32'hDEADBEEF) begin
        bad++; $display("FAIL wr_rd u%0d got a=%h b=%h exp deadbeef", k, ra[k], rb[k]);
      end
    end
    rd_addr_a = 4; #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ra[k] !== 0) begin bad++; $display("FAIL wr_rd_e4 u%0d got %h exp 0", k, ra[k]); end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_b [3] = '{32'h12345678, 32'h0, 32'h12345678};
    rd_addr_a = 3; wr_en = 1; wr_addr = 3; wr_data = 32'h12345678; #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ra[k] !== exp_b[k]) begin bad++; $display("FAIL bypass u%0d got %h exp %h", k, ra[k], exp_b[k]); end
    end
    cyc();
    wr_en = 0; #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ra[k] !== 32'h12345678) begin bad++; $display("FAIL bypass_after u%0d got %h exp 12345678", k, ra[k]); end
    end
  endtask

  task automatic test_zero();
    logic [31:0] exp_z [3] = '{32'h0, 32'hFFFFFFFF, 32'h0};
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    cyc();
    wr_en = 0; rd_addr_a = 0; rd_addr_b = 0; #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ra[k] !== exp_z[k] || rb[k] !== exp_z[k]) begin
        bad++; $display("FAIL zero u%0d got a=%h b=%h exp %h", k, ra[k], rb[k], exp_z[k]);
      end
    end
  endtask

  task automatic test_clear();
    int n [3] = '{0, 0, 0};
    fill(0);
    scrub_req = 1; cyc(); scrub_req = 0;
    for (int c = 0; c < 40; c++) begin
      wr_en = (c == 5); wr_addr = 10; wr_data = 32'hBAD0BAD0;
      rd_addr_a = (c == 3) ? 4'd2 : (c == 6) ? 4'd10 : 4'($urandom);
      rd_addr_b = (c == 3) ? 4'd3 : 4'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (bz[k]) n[k]++;
        total++;
        if (ra[k] !== exp_rd(k, rd_addr_a) || rb[k] !== exp_rd(k, rd_addr_b) || bz[k] !== (pos[k] >= 0)) begin
          bad++; $display("FAIL clear_walk u%0d c=%0d got a=%h b=%h busy=%b exp %h %h %b", k, c, ra[k], rb[k],
            bz[k], exp_rd(k, rd_addr_a), exp_rd(k, rd_addr_b), pos[k] >= 0);
        end
      end
      if (c == 3) begin
        total++;
        if (ra[0] !== 0 || rb[0] !== 32'd4) begin
          bad++; $display("FAIL clear_partial got e2=%h e3=%h exp 0 4", ra[0], rb[0]);
        end
      end
      if (c == 6) begin
        total++;
        if (ra[0] !== 32'd11) begin bad++; $display("FAIL clear_drop got %h exp 0000000b", ra[0]); end
      end
      cyc();
    end
    wr_en = 0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (n[k] !== (k == 2 ? 12 : 16)) begin
        bad++; $display("FAIL busy_len u%0d got %0d exp %0d", k, n[k], k == 2 ? 12 : 16);
      end
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a); #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (ra[k] !== 0) begin bad++; $display("FAIL clear_done u%0d addr %0d got %h exp 0", k, a, ra[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    fill(1);
    scrub_req = 1; cyc(); scrub_req = 0;
    repeat (6) cyc();
    total++;
    if (bz[0] !== 1) begin bad++; $display("FAIL mid_busy got %b exp 1", bz[0]); end
    clr_n = 0; #1;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a); rd_addr_b = 4'(a); #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (ra[k] !== 0 || rb[k] !== 0 || bz[k] !== 0) begin
          bad++; $display("FAIL mid_reset u%0d addr %0d got a=%h b=%h busy=%b exp 0", k, a, ra[k], rb[k], bz[k]);
        end
      end
    end
    clr_n = 1;
    @(negedge clk);
    wr_en = 1; wr_addr = 9; wr_data = 32'hA5;
    cyc();
    wr_en = 0; rd_addr_a = 9; #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ra[k] !== 32'hA5) begin bad++; $display("FAIL mid_rewrite u%0d got %h exp a5", k, ra[k]); end
    end
  endtask

  task automatic test_depth12();
    wr_en = 1; wr_addr = 13; wr_data = 32'h13131313;
    cyc();
    wr_en = 0;
    for (int a = 12; a < 16; a++) begin
      rd_addr_a = 4'(a); rd_addr_b = 4'(a); #1;
      total++;
      if (ra[2] !== 0 || rb[2] !== 0) begin
        bad++; $display("FAIL d12_oor addr %0d got a=%h b=%h exp 0", a, ra[2], rb[2]);
      end
    end
    rd_addr_a = 13; #1;
    total++;
    if (ra[0] !== 32'h13131313) begin bad++; $display("FAIL d12_ref got %h exp 13131313", ra[0]); end
  endtask

  task automatic test_random(input int cycles, input bit hold_scrub);
    for (int c = 0; c < cycles; c++) begin
      scrub_req = hold_scrub || ($urandom_range(0, 19) == 0);
      wr_en = $urandom_range(0, 1); wr_addr = 4'($urandom); wr_data = $urandom;
      rd_addr_a = $urandom_range(0, 1) ? wr_addr : 4'($urandom); rd_addr_b = 4'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (ra[k] !== exp_rd(k, rd_addr_a) || rb[k] !== exp_rd(k, rd_addr_b) || bz[k] !== (pos[k] >= 0)) begin
          bad++; $display("FAIL random%0s u%0d c=%0d got a=%h b=%h busy=%b exp %h %h %b", hold_scrub ? "_b2b" : "",
            k, c, ra[k], rb[k], bz[k], exp_rd(k, rd_addr_a), exp_rd(k, rd_addr_b), pos[k] >= 0);
        end
      end
      cyc();
    end
    scrub_req = 0; wr_en = 0;
  endtask

  initial begin
    rd_addr_a = 0; rd_addr_b = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero();
    test_clear();
    test_reset_mid();
    test_depth12();
    test_random(300, 0);
    test_random(60, 1);
    repeat (20) cyc();
    test_random(100, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
